// File: rtl/alu_cmd_issue_if.sv
// Bundle for the command-issue stage: command push channel, ALU drive/return,
// result handshake and status. The slave modport is the issue block's view;
// the master modport is the surrounding environment (producer, ALU, consumer).
interface alu_cmd_issue_if #(
  parameter int LVL_W = 3
) ();
  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  // ALU drive and return
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_pass;
  logic             alu_add;
  logic [7:0]       alu_result;
  // Result channel and status
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [7:0]       acc;
  logic [LVL_W-1:0] fifo_level;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_pass, alu_add,
           res_valid, res_data, acc, fifo_level
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_pass, alu_add,
           res_valid, res_data, acc, fifo_level
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of an 8-bit combinational ALU. Commands are
// queued in a small FIFO, the ALU is driven from the FIFO head, and the ALU
// result is captured into a registered output with a valid/ready handshake.
// An accumulator tracks the last issued result so op 11 can chain additions.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_cmd_issue_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_ACC  = 2'b11;

  // FIFO storage and pointers (pointers carry one extra wrap bit)
  logic [1:0]       r_op_mem [DEPTH];
  logic [7:0]       r_a_mem  [DEPTH];
  logic [7:0]       r_b_mem  [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;

  // Result stage registers
  logic             r_res_vld_p1;
  logic [7:0]       r_res_data_p1;
  logic [7:0]       r_acc_p1;

  logic [LVL_W-1:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_issue;
  logic [1:0]       w_head_op;
  logic [7:0]       w_head_a;
  logic [7:0]       w_head_b;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == LVL_W'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_push    = bus.cmd_valid && !w_full;
  // Issue whenever a command is queued and the result register is free or draining
  assign w_issue   = !w_empty && (!r_res_vld_p1 || bus.res_ready);

  assign w_head_op = r_op_mem[r_rd_ptr[IDX_W-1:0]];
  assign w_head_a  = r_a_mem[r_rd_ptr[IDX_W-1:0]];
  assign w_head_b  = r_b_mem[r_rd_ptr[IDX_W-1:0]];

  // Write command payload at the tail; storage needs no reset since level gates it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr[IDX_W-1:0]] <= bus.cmd_op;
      r_a_mem[r_wr_ptr[IDX_W-1:0]]  <= bus.cmd_a;
      r_b_mem[r_wr_ptr[IDX_W-1:0]]  <= bus.cmd_b;
    end
  end

  // Advance FIFO pointers on push and on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Drive ALU operands/controls from the FIFO head; idle drive is all zeros
  always_comb begin
    bus.alu_a    = 8'd0;
    bus.alu_b    = 8'd0;
    bus.alu_pass = 1'b0;
    bus.alu_add  = 1'b0;
    if (!w_empty) begin
      bus.alu_a = w_head_a;
      case (w_head_op)
        OP_ZERO: begin
          bus.alu_pass = 1'b0;
          bus.alu_add  = 1'b0;
        end
        OP_PASS: begin
          bus.alu_pass = 1'b1;
        end
        OP_ADD: begin
          bus.alu_add = 1'b1;
          bus.alu_b   = w_head_b;
        end
        OP_ACC: begin
          // acc is the previous issued result, so back-to-back chains see it
          bus.alu_add = 1'b1;
          bus.alu_b   = r_acc_p1;
        end
        default: begin
          bus.alu_pass = 1'b0;
          bus.alu_add  = 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: capture ALU result, update accumulator, handshake out ----
  // Capture result and accumulator on issue; clear valid on a drain-only edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_vld_p1  <= 1'b0;
      r_res_data_p1 <= 8'd0;
      r_acc_p1      <= 8'd0;
    end else if (w_issue) begin
      r_res_vld_p1  <= 1'b1;
      r_res_data_p1 <= bus.alu_result;
      r_acc_p1      <= bus.alu_result;
    end else if (r_res_vld_p1 && bus.res_ready) begin
      r_res_vld_p1  <= 1'b0;
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.res_valid  = r_res_vld_p1;
  assign bus.res_data   = r_res_data_p1;
  assign bus.acc        = r_acc_p1;
  assign bus.fifo_level = w_level;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural model of the 8-bit ALU.
module tb_alu_cmd_issue;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_cmd_issue_if #(.LVL_W(3)) bus ();

  alu_cmd_issue #(.DEPTH(4), .LVL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 8-bit ALU: pass selects a, add gives a+b mod 256, otherwise zero
  assign bus.alu_result = bus.alu_pass ? bus.alu_a :
                          bus.alu_add  ? 8'(bus.alu_a + bus.alu_b) : 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    bus.res_ready = 1'b1;
    #2;
    // reset state
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_pass, bus.alu_add}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single add 10+13
    drive(1'b1, 2'b10, 8'd10, 8'd13);
    tick();
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    chk("t1_level", bus.fifo_level, 1);
    chk("t1_alu_a", bus.alu_a, 10);
    chk("t1_alu_b", bus.alu_b, 13);
    chk("t1_alu_add", bus.alu_add, 1);
    chk("t1_vld_pre", bus.res_valid, 0);
    tick();
    chk("t1_vld", bus.res_valid, 1);
    chk("t1_data", bus.res_data, 23);
    chk("t1_acc", bus.acc, 23);
    chk("t1_level0", bus.fifo_level, 0);
    tick();
    chk("t1_vld_drop", bus.res_valid, 0);
    chk("t1_data_hold", bus.res_data, 23);

    // back-to-back pass / zero / add
    drive(1'b1, 2'b01, 8'd12, 8'd99);
    tick();
    chk("t2_alu_pass", bus.alu_pass, 1);
    chk("t2_alu_b_pass", bus.alu_b, 0);
    drive(1'b1, 2'b00, 8'd5, 8'd77);
    tick();
    chk("t2_r0", bus.res_data, 12);
    chk("t2_acc0", bus.acc, 12);
    chk("t2_zero_a", bus.alu_a, 5);
    chk("t2_zero_ctl", {bus.alu_b, bus.alu_pass, bus.alu_add}, 0);
    drive(1'b1, 2'b10, 8'd20, 8'd20);
    tick();
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    chk("t2_r1", bus.res_data, 0);
    chk("t2_acc1", bus.acc, 0);
    tick();
    chk("t2_r2", bus.res_data, 40);
    chk("t2_vld2", bus.res_valid, 1);
    chk("t2_empty_alu", {bus.alu_a, bus.alu_b, bus.alu_pass, bus.alu_add}, 0);
    tick();
    chk("t2_vld_drop", bus.res_valid, 0);

    // accumulator chaining with wrap
    drive(1'b1, 2'b01, 8'd200, 8'd0);
    tick();
    drive(1'b1, 2'b11, 8'd100, 8'd7);
    tick();
    chk("t3_r0", bus.res_data, 200);
    chk("t3_alu_b_acc", bus.alu_b, 200);
    drive(1'b1, 2'b11, 8'd100, 8'd7);
    tick();
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    chk("t3_r1_wrap", bus.res_data, 44);
    chk("t3_alu_b_acc2", bus.alu_b, 44);
    tick();
    chk("t3_r2", bus.res_data, 144);
    chk("t3_acc", bus.acc, 144);
    tick();

    // stall with res_ready low, fill the FIFO
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 2'b01, 8'(i), 8'd0);
      tick();
    end
    chk("t4_level_full", bus.fifo_level, 4);
    chk("t4_cmd_ready", bus.cmd_ready, 0);
    chk("t4_vld", bus.res_valid, 1);
    chk("t4_first_held", bus.res_data, 1);
    drive(1'b1, 2'b01, 8'd6, 8'd0);
    tick();
    chk("t4_level_still", bus.fifo_level, 4);
    chk("t4_first_held2", bus.res_data, 1);

    // release while full and still offering command 6
    bus.res_ready = 1'b1;
    tick();
    chk("t5_r2", bus.res_data, 2);
    chk("t5_level3", bus.fifo_level, 3);
    chk("t5_ready_up", bus.cmd_ready, 1);
    tick();
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    chk("t5_r3", bus.res_data, 3);
    chk("t5_level_pushpop", bus.fifo_level, 3);
    tick();
    chk("t5_r4", bus.res_data, 4);
    tick();
    chk("t5_r5", bus.res_data, 5);
    tick();
    chk("t5_r6", bus.res_data, 6);
    chk("t5_level0", bus.fifo_level, 0);
    tick();
    chk("t5_vld_drop", bus.res_valid, 0);

    // asynchronous reset with queued commands and pending result
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 8'd1, 8'd1);
      tick();
    end
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    chk("t6_level3", bus.fifo_level, 3);
    chk("t6_vld", bus.res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ar_vld", bus.res_valid, 0);
    chk("t6_ar_data", bus.res_data, 0);
    chk("t6_ar_acc", bus.acc, 0);
    chk("t6_ar_level", bus.fifo_level, 0);
    chk("t6_ar_ready", bus.cmd_ready, 1);
    chk("t6_ar_alu", {bus.alu_a, bus.alu_b, bus.alu_pass, bus.alu_add}, 0);
    tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    drive(1'b1, 2'b10, 8'd1, 8'd2);
    tick();
    drive(1'b0, 2'b00, 8'd0, 8'd0);
    tick();
    chk("t6_post_data", bus.res_data, 3);
    chk("t6_post_vld", bus.res_valid, 1);
    chk("t6_post_level", bus.fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Command-issue stage that sits directly upstream of the 8-bit combinational ALU (operands `a`, `b`, controls `pass`, `add`, result `alu_out`). It buffers operation commands in a small FIFO, drives the ALU operand and control inputs from the FIFO head, and captures the ALU result into a registered output with a valid/ready handshake. It also keeps an 8-bit accumulator so that chained additions can run without the producer re-supplying the previous result.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO depth. Must be a power of 2, at least 2.
- `LVL_W`, default 3: width of `fifo_level`. Must equal log2(DEPTH)+1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command; equals !full.
- `cmd_op`  in  2  00 = zero, 01 = pass a, 10 = a+b, 11 = a+acc.
- `cmd_a`  in  8  operand a.
- `cmd_b`  in  8  operand b; ignored for ops 00, 01 and 11.
- `alu_a`  out  8  to ALU `a`.
- `alu_b`  out  8  to ALU `b`.
- `alu_pass`  out  1  to ALU `pass`.
- `alu_add`  out  1  to ALU `add`.
- `alu_result`  in  8  from ALU `alu_out`; combinational function of `alu_*`.
- `res_valid`  out  1  result register holds data.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  8  registered result.
- `acc`  out  8  current accumulator value.
- `fifo_level`  out  LVL_W  number of queued commands (0..DEPTH).

## Operation
- Push: `cmd_valid && cmd_ready` writes {op, a, b} at the tail.
- Issue condition: FIFO non-empty && (!res_valid || res_ready).
  - On the issue edge: `res_data <= alu_result`, `res_valid <= 1`, `acc <= alu_result`, and the head is popped.
- ALU drive is combinational from the FIFO head:
  - FIFO empty: `alu_a`=0, `alu_b`=0, `alu_pass`=0, `alu_add`=0.
  - op 00: pass=0, add=0; a = head a, b = 0.
  - op 01: pass=1, add=0; a = head a, b = 0.
  - op 10: pass=0, add=1; a = head a, b = head b.
  - op 11: pass=0, add=1; a = head a, b = `acc`.
- Result drain: `res_valid && res_ready` with no issue on the same edge clears `res_valid`. `res_data` holds its value.
- Arithmetic: the ALU sum is 8-bit modulo 256. There is no carry; overflow wraps silently.
- `acc` is updated by every issued op, including op 00 (acc <= 0) and op 01 (acc <= a).
- Each pointer is LVL_W bits wide and wraps naturally. Full = level==DEPTH; empty = level==0.
- Simultaneous push and pop: `fifo_level` is unchanged. When full, `cmd_ready`=0, so a push cannot coincide with the pop on that edge (no pass-through).
- The block issues no command while the output is stalled (`res_valid && !res_ready`). The FIFO keeps accepting until full.

## Timing
- Reset (asynchronous assert, synchronous release on the first clk edge after deassert):
  - `cmd_ready`=1, `res_valid`=0, `res_data`=0, `acc`=0, `fifo_level`=0.
  - FIFO empty, so `alu_a`=0, `alu_b`=0, `alu_pass`=0, `alu_add`=0.
- Reset mid-operation discards all queued commands and any pending result. No partial state survives.
- Latency, empty FIFO and idle output:
  - Command accepted at edge E0.
  - ALU is driven during the cycle after E0.
  - Result is captured at E1 = E0+1; `res_valid`=1 after E1.
- Throughput is 1 result per cycle with `res_ready` held high. Back-to-back op 11 commands chain correctly because `acc` updates on the same edge as the issue.
- `cmd_ready` and `res_valid` are registered-state functions. `alu_*` are combinational from FIFO and `acc` state only, never from `cmd_*` inputs.

## Test plan
- Reset, then push {op10, a=10, b=13} with `res_ready`=1 → `res_data`=23 one edge after acceptance; `acc`=23; `res_valid` pulses for 1 cycle.
- Push op01 a=12, op00 a=5, and op10 a=20 b=20 back-to-back with `res_ready`=1 → results 12, 0, 40 on consecutive cycles; `alu_*`=0 once the FIFO is empty.
- Push op01 a=200, then op11 a=100 twice → results 200, 44 (300 mod 256), 144; `acc`=144.
- Hold `res_ready`=0 and push 6 commands → `res_valid`=1 with the first result held stable; `fifo_level` reaches 4 (DEPTH) and `cmd_ready`=0. Then release `res_ready` → remaining results in order, one per cycle.
- Full FIFO with `cmd_valid`=1 and `res_ready`=1 → one pop per edge, a push only on the edge after `cmd_ready` rises, and no command lost or duplicated.
- Assert `rst_n`=0 asynchronously while 3 commands are queued and `res_valid`=1 → all outputs reach their reset values immediately without a clock edge; after release, a push of {op10, a=1, b=2} gives 3.
